// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM port controller and its response FIFO.
package sram_ctrl_pkg;

  // Controller phase: clear sweep after reset, then normal request service.
  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // Defaults match the sky130_sram_2rw_32x128_32 macro.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 7;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding read data until the client pops it.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = 2,
  localparam int CW = count_width(RSP_DEPTH),
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Pointer increment that wraps at RSP_DEPTH, so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(RSP_DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Data storage written on push.
  // NOTE: storage has no reset; empty gates the head output, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign empty    = (count == '0);
  assign full     = (count == CW'(RSP_DEPTH));
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator for one RW port of an OpenRAM 2RW macro: clear sweep after reset,
// then valid/ready requests to registered csb/web/addr/din strobes, with read
// data captured into a credit-limited response FIFO.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    RSP_DEPTH  = 2,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int CW  = count_width(RSP_DEPTH);
  localparam int CW1 = CW + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_last;
  logic                  inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  accept;
  logic [CW1-1:0]        credit_used;

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;

  // Slots already claimed: queued words plus the read in flight, less the one leaving now.
  assign credit_used = CW1'(fifo_count) + CW1'(inflight) - CW1'(pop);

  // Ready is a function of controller state only, never of req_valid; the full
  // term is implied by the credit test but keeps the FIFO guarded on its own.
  assign req_ready = init_done && (state == ST_RUN) &&
                     (credit_used < CW1'(RSP_DEPTH)) && !(fifo_full && !pop);
  assign accept    = req_valid && req_ready;

  // Controller FSM: drives every macro strobe from a register so the macro sees clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_EN ? ST_INIT : ST_RUN;
      init_addr <= '0;
      init_last <= 1'b0;
      inflight  <= 1'b0;
      init_done <= 1'b0;
      sram_csb  <= 1'b1;
      sram_web  <= 1'b1;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          inflight <= 1'b0;
          if (init_last) begin
            sram_csb  <= 1'b1;
            sram_web  <= 1'b1;
            state     <= ST_RUN;
            init_done <= 1'b1;
          end else begin
            sram_csb  <= 1'b0;
            sram_web  <= 1'b0;
            sram_addr <= init_addr;
            sram_din  <= INIT_VALUE;
            // Counter parks on the top address instead of wrapping to 0.
            if (init_addr == LAST_ADDR) init_last <= 1'b1;
            else                        init_addr <= init_addr + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          init_done <= 1'b1;
          sram_csb  <= !accept;
          sram_web  <= !(accept && req_we);
          if (accept) begin
            sram_addr <= req_addr;
            sram_din  <= req_wdata;
          end
          inflight  <= accept && !req_we;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // dout is captured only the edge after a read was issued, so idle-cycle X never enters the FIFO.
  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (sram_dout),
    .pop       (pop),
    .pop_data  (rsp_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Scoreboard bench for sram_port_ctrl with a behavioural model of the OpenRAM port.
module tb_sram_port_ctrl;
  localparam int DW        = 32;
  localparam int AW        = 7;
  localparam int DEPTH     = 1 << AW;
  localparam int RSP_DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_csb;
  logic          sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_accept = 0;

  sram_port_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RSP_DEPTH  (RSP_DEPTH),
    .INIT_EN    (1'b1),
    .INIT_VALUE ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  always #5 clk = ~clk;

  // Macro model: write lands on negedge, read is combinational from the registered command.
  always @(negedge clk) if (!sram_csb && !sram_web) sram_mem[sram_addr] <= sram_din;
  assign sram_dout = (!sram_csb && sram_web) ? sram_mem[sram_addr] : 'x;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {sram_csb, sram_web, sram_addr, sram_din, req_ready, rsp_valid, init_done},
                {1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, 1'b0});
    check({name, "_rdata"}, rsp_rdata, 0);
  endtask

  // Follows the sweep edge by edge from reset release up to edge last_k.
  task automatic sweep_check(input int last_k);
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk); #1;
      check("init_word", {sram_csb, sram_web, sram_addr, sram_din, req_ready, init_done},
                         {1'b0, 1'b0, AW'(k - 1), {DW{1'b0}}, 1'b0, 1'b0});
    end
  endtask

  // Presents one request from a negedge and holds it until accepted; returns cycles stalled.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        output int stalls);
    int waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    forever begin
      #1;
      if (req_ready) begin
        @(posedge clk);
        if (we) ref_mem[addr] = data;
        else    exp_q.push_back(ref_mem[addr]);
        n_accept++;
        break;
      end
      waited++;
      if (waited > 200) begin
        n_checks++;
        $display("FAIL req_timeout: addr %0d still not accepted after %0d cycles", addr, waited);
        break;
      end
      @(negedge clk);
    end
    stalls = waited;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a response, and
  // checks that outstanding reads never exceed the response buffer.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        check("credit_limit", exp_q.size() <= RSP_DEPTH, 1);
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got %h expected no response", rsp_rdata);
          end else begin
            check("rsp_data", rsp_rdata, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int st;
    int total;
    int base;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset values, asserted before any clock edge.
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset_vals");
    repeat (3) @(posedge clk);
    check_reset_outputs("reset_held");
    @(negedge clk) rst_n = 1'b1;

    // Interrupt the sweep at address 60, then require a full restart.
    sweep_check(61);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_init_reset");
    @(negedge clk) rst_n = 1'b1;
    sweep_check(DEPTH);
    @(posedge clk); #1;
    check("init_done_edge", {sram_csb, sram_web, init_done, req_ready}, 4'b1111);

    // Cleared memory reads back as zero.
    do_req(1'b0, AW'(0),   '0, st);
    do_req(1'b0, AW'(64),  '0, st);
    do_req(1'b0, AW'(127), '0, st);
    idle();
    repeat (3) @(posedge clk);

    // Write then read same address on the next edge; one-cycle read latency.
    do_req(1'b1, AW'(5), 32'hDEAD_BEEF, st);
    do_req(1'b0, AW'(5), '0, st);
    #1 check("lat_not_early", rsp_valid, 0);
    idle();
    @(posedge clk); #1;
    check("lat_valid", rsp_valid, 1);
    check("lat_data", rsp_rdata, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk);

    // Back-to-back reads with the consumer always ready never stall.
    for (int i = 0; i < 8; i++) do_req(1'b1, AW'(i), DW'(i * 3), st);
    total = 0;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, AW'(i), '0, st);
      total += st;
    end
    check("b2b_stalls", total, 0);
    idle();
    repeat (3) @(posedge clk);

    // Backpressure: only RSP_DEPTH reads accepted while the consumer stalls.
    @(negedge clk) rsp_ready = 1'b0;
    base = n_accept;
    fork
      begin
        int st_f;
        for (int i = 0; i < 4; i++) do_req(1'b0, AW'(i), '0, st_f);
      end
      begin
        repeat (6) @(negedge clk);
        #3;
        check("stall_accepted", n_accept - base, 2);
        check("stall_ready", req_ready, 0);
        @(negedge clk) rsp_ready = 1'b1;
      end
    join
    check("stall_all_accepted", n_accept - base, 4);
    idle();
    repeat (3) @(posedge clk);

    // Top and bottom addresses hold distinct data.
    do_req(1'b1, AW'(127), 32'hA5A5_A5A5, st);
    do_req(1'b1, AW'(0),   32'h0000_0001, st);
    do_req(1'b0, AW'(127), '0, st);
    do_req(1'b0, AW'(0),   '0, st);
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Initiator/controller for one RW port of the 2RW OpenRAM macro (sky130_sram_2rw_32x128_32 / _64x128_64).
- Converts a valid/ready request stream into the macro's csb/web/addr/din strobes.
- Captures dout into a response FIFO with backpressure.
- After reset, runs an init sweep that writes INIT_VALUE to every word, because the macro powers up X.
- Sits between a client (cache, DMA) and the macro; the macro's clk port is tied to this block's clk in the parent.

Parameters:
- DATA_WIDTH, 32, word width; must match the macro.
- ADDR_WIDTH, 7, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- RSP_DEPTH, 2, response FIFO entries (>=2).
- INIT_EN, 1, 1 = run the clear sweep after reset; 0 = skip it.
- INIT_VALUE, 0, word written during the sweep.

Ports:
- clk  in  1  clock, shared with the macro port clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid && ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  read data valid (FIFO head)
- rsp_ready  in  1  consumer pops the head
- rsp_rdata  out  DATA_WIDTH  read data
- init_done  out  1  sweep complete; requests may be accepted
- sram_csb  out  1  macro chip select, active low
- sram_web  out  1  macro write enable, active low
- sram_addr  out  ADDR_WIDTH  macro address
- sram_din  out  DATA_WIDTH  macro write data
- sram_dout  in  DATA_WIDTH  macro read data

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Values while rst_n is low:
  - sram_csb=1, sram_web=1, sram_addr=0, sram_din=0
  - req_ready=0, rsp_valid=0, init_done=0
  - FIFO empty, in-flight flag=0, state=INIT (INIT_EN=1) or RUN (INIT_EN=0)
  - rsp_rdata=0 whenever the FIFO is empty
- All macro-side outputs are registered and change only on posedge clk. The macro writes on negedge and reads combinationally, so a command registered at edge T completes within cycle T.
- INIT state:
  - Posedge k after reset release (k=1..RAM_DEPTH) drives csb=0, web=0, addr=k-1, din=INIT_VALUE.
  - At edge RAM_DEPTH+1: csb=1, web=1, state becomes RUN, init_done=1.
  - init_done stays 1 until the next reset.
  - With INIT_EN=0, init_done=1 from the first posedge after reset release.
  - req_ready=0 throughout INIT.
- RUN state:
  - req_ready = RUN && (fifo_count + inflight - pop < RSP_DEPTH), where pop = rsp_valid && rsp_ready.
  - req_ready never depends on req_valid.
  - Writes obey the same credit rule.
- Accept at edge T: sram_csb=0, sram_web=~req_we, sram_addr=req_addr, sram_din=req_wdata (din is don't-care for reads but is still registered).
- No accept at edge T: sram_csb=1, sram_web=1; addr and din hold their previous values.
- Read accepted at edge T: inflight=1 during cycle T; at edge T+1 sram_dout is pushed into the FIFO and inflight clears (unless another read is accepted at T+1). rsp_valid rises after edge T+1, so latency is 1 cycle from accept to rsp_valid.
- Writes produce no response.
- Throughput: with rsp_ready held at 1, one read per cycle sustained.
- Ordering: a read accepted the cycle after a write to the same address returns the new data (the write lands at the negedge of cycle T).
- Simultaneous push and pop: count unchanged, head advances.
- Pop on empty is impossible (rsp_valid=0). Push when full cannot occur because of the credit rule; the bench asserts this.
- sram_dout is sampled only when inflight=1; X on idle cycles must not propagate.
- Address wrap: no auto-increment; the INIT counter stops at RAM_DEPTH-1 and does not wrap.
- Reset asserted mid-operation: outputs go to reset values immediately, FIFO and in-flight read are discarded, INIT restarts on release.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum {INIT, RUN}
  - default DATA_WIDTH/ADDR_WIDTH constants matching the macro
  - the FIFO count width function (clog2(RSP_DEPTH+1))
- Sub-module sram_rsp_fifo: synchronous FIFO, parameters DATA_WIDTH and RSP_DEPTH, ports push/pop/data/count/empty/full, same clk/rst_n.

Test Plan:
- Reset release with INIT_EN=1, DEPTH 128 → sram_csb=0, web=0 for exactly 128 cycles with addr 0..127 and din=0; init_done rises at edge 129; any read returns 0.
- Write addr 5 = 0xDEADBEEF at edge T, read addr 5 at edge T+1 → rsp_valid after edge T+2 with rsp_rdata=0xDEADBEEF.
- Writes 0..7 with data=addr*3, then 8 back-to-back reads with rsp_ready=1 → req_ready stays 1, responses 0,3,...,21 on consecutive cycles.
- rsp_ready=0, issue 4 reads → only 2 accepted, req_ready=0. Raise rsp_ready → remaining reads accepted; responses arrive in order, none lost or duplicated.
- rst_n low at init address 60, then released → outputs return to reset values asynchronously; sweep restarts at addr 0; init_done only after 128 further writes.
- Write addr 127 = 0xA5A5A5A5 and addr 0 = 0x1 → reading 127 then 0 returns 0xA5A5A5A5 then 0x1 (no aliasing at the top address).
